// File: rtl/ram_bist_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : ram_bist_if                                           |
// | Brief    : Single-port synchronous RAM bus between BIST and RAM  |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
interface ram_bist_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic [DATA_WIDTH-1:0] ram_dout;

  modport master (
    output ram_we,
    output ram_addr,
    output ram_din,
    input  ram_dout
  );

  modport slave (
    input  ram_we,
    input  ram_addr,
    input  ram_din,
    output ram_dout
  );
endinterface
`default_nettype wire

// File: rtl/ram_bist.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : ram_bist                                              |
// | Brief    : Up/down write-read march test with first-fail capture |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module ram_bist #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] PATTERN    = DATA_WIDTH'(8'hA5)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data,
  ram_bist_if.master            ram
);

  localparam logic [2:0] c_IDLE     = 3'd0;
  localparam logic [2:0] c_WR_UP    = 3'd1;
  localparam logic [2:0] c_RD_UP    = 3'd2;
  localparam logic [2:0] c_DRAIN_UP = 3'd3;
  localparam logic [2:0] c_WR_DN    = 3'd4;
  localparam logic [2:0] c_RD_DN    = 3'd5;
  localparam logic [2:0] c_DRAIN_DN = 3'd6;
  localparam logic [2:0] c_FIN      = 3'd7;

  localparam logic [ADDR_WIDTH-1:0] c_ADDR_LAST = '1;

  // Address is zero-extended or truncated to the word width before the XOR.
  function automatic logic [DATA_WIDTH-1:0] f_pat(input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH+ADDR_WIDTH-1:0] ext;
    ext = {{DATA_WIDTH{1'b0}}, a};
    return PATTERN ^ ext[DATA_WIDTH-1:0];
  endfunction

  logic [2:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_cmp_valid;
  logic [DATA_WIDTH-1:0] r_exp;
  logic [ADDR_WIDTH-1:0] r_cmp_addr;
  logic                  r_pass;
  logic [ADDR_WIDTH-1:0] r_fail_addr;
  logic [DATA_WIDTH-1:0] r_fail_data;
  logic                  w_mismatch;

  assign w_mismatch = r_cmp_valid && (ram.ram_dout != r_exp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_IDLE;
      r_addr      <= '0;
      r_cmp_valid <= 1'b0;
      r_exp       <= '0;
      r_cmp_addr  <= '0;
      r_pass      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_data <= '0;
    end else begin
      r_cmp_valid <= 1'b0;
      // A miscompare aborts whatever phase is running, including a drain cycle.
      if (w_mismatch) begin
        r_fail_addr <= r_cmp_addr;
        r_fail_data <= ram.ram_dout;
        r_state     <= c_FIN;
      end else begin
        case (r_state)
          c_IDLE: begin
            if (start) begin
              r_state     <= c_WR_UP;
              r_addr      <= '0;
              r_pass      <= 1'b0;
              r_fail_addr <= '0;
              r_fail_data <= '0;
            end
          end
          c_WR_UP: begin
            if (r_addr == c_ADDR_LAST) begin
              r_state <= c_RD_UP;
              r_addr  <= '0;
            end else begin
              r_addr <= r_addr + 1'b1;
            end
          end
          c_RD_UP: begin
            r_cmp_valid <= 1'b1;
            r_exp       <= f_pat(r_addr);
            r_cmp_addr  <= r_addr;
            if (r_addr == c_ADDR_LAST) r_state <= c_DRAIN_UP;
            else                       r_addr  <= r_addr + 1'b1;
          end
          c_DRAIN_UP: begin
            r_state <= c_WR_DN;
            r_addr  <= c_ADDR_LAST;
          end
          c_WR_DN: begin
            if (r_addr == '0) begin
              r_state <= c_RD_DN;
              r_addr  <= c_ADDR_LAST;
            end else begin
              r_addr <= r_addr - 1'b1;
            end
          end
          c_RD_DN: begin
            r_cmp_valid <= 1'b1;
            r_exp       <= ~f_pat(r_addr);
            r_cmp_addr  <= r_addr;
            if (r_addr == '0) r_state <= c_DRAIN_DN;
            else              r_addr  <= r_addr - 1'b1;
          end
          c_DRAIN_DN: begin
            r_state <= c_FIN;
            r_pass  <= 1'b1;
          end
          c_FIN: begin
            r_state <= c_IDLE;
            r_addr  <= '0;
          end
          default: r_state <= c_IDLE;
        endcase
      end
    end
  end

  assign busy      = (r_state != c_IDLE) && (r_state != c_FIN);
  assign done      = (r_state == c_FIN);
  assign pass      = r_pass;
  assign fail_addr = r_fail_addr;
  assign fail_data = r_fail_data;

  assign ram.ram_we   = (r_state == c_WR_UP) || (r_state == c_WR_DN);
  assign ram.ram_addr = r_addr;
  assign ram.ram_din  = (r_state == c_WR_UP) ? f_pat(r_addr)  :
                        (r_state == c_WR_DN) ? ~f_pat(r_addr) : '0;

endmodule
`default_nettype wire

// File: doc/ram_bist.md
RAM_BIST -- requirements
Module: ram_bist

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, the RAM word width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 4, the RAM address width; N = 2**ADDR_WIDTH locations.
REQ-003 The block SHALL have parameter PATTERN, default 8'hA5 (sized to DATA_WIDTH), the base test pattern.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit, a run request sampled on the rising edge.
REQ-007 The block SHALL have port busy, output, 1 bit, high while a run is in progress.
REQ-008 The block SHALL have port done, output, 1 bit, a one-cycle pulse at run end.
REQ-009 The block SHALL have port pass, output, 1 bit, the result of the last completed run.
REQ-010 The block SHALL have port fail_addr, output, ADDR_WIDTH bits, the first failing address.
REQ-011 The block SHALL have port fail_data, output, DATA_WIDTH bits, the data read at the first failure.
REQ-012 The block SHALL have port ram_we, output, 1 bit, the RAM write enable.
REQ-013 The block SHALL have port ram_addr, output, ADDR_WIDTH bits, the RAM address.
REQ-014 The block SHALL have port ram_din, output, DATA_WIDTH bits, the RAM write data.
REQ-015 The block SHALL have port ram_dout, input, DATA_WIDTH bits, the RAM read data, valid one cycle after the address is presented with ram_we=0.

Function
REQ-016 Expected data SHALL be D(a) = PATTERN XOR a, with a zero-extended or truncated to DATA_WIDTH.
REQ-017 The FSM SHALL have states IDLE, WR_UP, RD_UP, DRAIN_UP, WR_DN, RD_DN, DRAIN_DN, FIN.
REQ-018 In IDLE, start=1 SHALL move to WR_UP, clear pass/fail_addr/fail_data, and set busy on the same edge.
REQ-019 WR_UP SHALL drive ram_we=1, ram_addr=0..N-1 ascending, ram_din=D(addr), one address per cycle, for N cycles.
REQ-020 RD_UP SHALL drive ram_we=0, ram_addr=0..N-1 ascending, and register the expected value and address one cycle later for compare.
REQ-021 DRAIN_UP SHALL last one cycle, with ram_we=0, and complete the compare for address N-1.
REQ-022 WR_DN SHALL drive ram_we=1, ram_addr=N-1..0 descending, ram_din=~D(addr), for N cycles.
REQ-023 RD_DN and DRAIN_DN SHALL mirror RD_UP and DRAIN_UP, descending, with expected value ~D(addr).
REQ-024 Each compare SHALL test ram_dout against the registered expected value, one cycle after the address was issued.
REQ-025 On the first mismatch, the block SHALL capture fail_addr (the address issued one cycle earlier) and fail_data=ram_dout, then go to FIN on that edge, aborting the rest of the run.
REQ-026 FIN SHALL last one cycle, assert done=1 and busy=0, set pass=1 only if no mismatch occurred, and return to IDLE.
REQ-027 A fault-free run SHALL keep busy high for exactly 4N+2 cycles, then one FIN cycle (66+1 for N=16).
REQ-028 start SHALL be ignored while busy or in FIN; start held high in IDLE SHALL begin a new run every time IDLE is re-entered.
REQ-029 pass, fail_addr and fail_data SHALL hold their values until the next accepted start.
REQ-030 The address counter SHALL be ADDR_WIDTH bits and SHALL never wrap within a phase; its terminal value (N-1 ascending, 0 descending) SHALL end the phase.
REQ-031 ram_we SHALL be 0 in every state except WR_UP and WR_DN.

Reset
REQ-032 rst_n=0 SHALL, asynchronously, force IDLE and set busy, done, pass, ram_we to 0 and fail_addr, fail_data, ram_addr, ram_din to 0, including mid-run.
REQ-033 After rst_n is released, the block SHALL stay idle until a rising edge samples start=1.

Verification
REQ-034 Fault-free RAM model, N=16, one-cycle start pulse -> busy high for 66 cycles, done pulse, pass=1, fail_addr=0.
REQ-035 RAM with bit 0 stuck-at-1 at address 5 (D(5)=8'hA0) -> failure in RD_UP, fail_addr=5, fail_data=8'hA1, pass=0, done after 16+6+1 compare cycles.
REQ-036 RAM that corrupts only inverted writes at address 3 -> RD_UP passes, failure in RD_DN, fail_addr=3, pass=0.
REQ-037 start pulsed again on cycle 10 of a run -> ignored; a single done pulse at the normal cycle count.
REQ-038 rst_n asserted in WR_DN -> ram_we, busy and ram_addr go to 0 immediately; a new start after release runs the full 66 cycles and passes.
REQ-039 start held high continuously -> back-to-back runs, each with a done pulse, separated by exactly one IDLE cycle.
